// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the
// clocks-per-bit calculation used by both uart_rx and uart_tx.
package uart_pkg;

   // Data bits per frame (LSB first on the wire)
   localparam int UART_DATA_BITS = 8;

   // Receiver FSM states. PARITY is only reachable in parity-enabled builds.
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } uart_rx_state_t;

   // System clocks per serial bit (integer division, truncating)
   function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for asynchronous inputs. Both stages reset to
// RST_VAL so an idle-high serial line does not look like a start bit
// while coming out of reset.
module uart_rx_sync #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // First stage may go metastable; only the second stage is consumed
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Synchronises rx_serial, validates the start bit at its midpoint, samples
// data/parity/stop bits one bit period apart, and emits one-cycle strobes
// for a good byte, a framing error or a parity error.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 115200
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rx_serial,
   output logic [UART_DATA_BITS-1:0] rx_data,
   output logic                      rx_valid,
   output logic                      rx_frame_err,
   output logic                      rx_parity_err,
   output logic                      rx_busy
);

   localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam int CW  = $clog2(CPB + 1);
   localparam int IW  = $clog2(UART_DATA_BITS);

   // Mid start bit and end of a full bit period, as counter values
   localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CPB - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(UART_DATA_BITS - 1);

   logic                      rx_s;
   uart_rx_state_t            state_q, state_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [IW-1:0]             idx_q, idx_d;
   logic [UART_DATA_BITS-1:0] sh_q, sh_d;
   logic [UART_DATA_BITS-1:0] data_q, data_d;
   logic                      valid_d, ferr_d;
   logic                      bit_end;

`ifdef UART_RX_PARITY_EN
   logic                      perr_q, perr_d;
   logic                      pstb_d;
`endif

   uart_rx_sync #(
      .WIDTH   (1),
      .RST_VAL (1'b1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx_serial),
      .q   (rx_s)
   );

   assign bit_end = (cnt_q == FULL_M1);
   assign rx_data = data_q;
   assign rx_busy = (state_q != IDLE);

   // Next-state, bit timing, shift register and strobe generation
   always_comb begin
      state_d = state_q;
      cnt_d   = bit_end ? '0 : cnt_q + CW'(1);
      idx_d   = idx_q;
      sh_d    = sh_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d  = perr_q;
      pstb_d  = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            idx_d = '0;
`ifdef UART_RX_PARITY_EN
            perr_d = 1'b0;
`endif
            if (!rx_s) state_d = START;
         end

         // Re-check the line half a bit in; a high line was only a glitch
         START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               state_d = rx_s ? IDLE : DATA;
            end
         end

         // Counter wraps at each bit end, so every sample lands mid-bit
         DATA: begin
            if (bit_end) begin
               sh_d[idx_q] = rx_s;
               idx_d       = idx_q + IW'(1);
               if (idx_q == LAST_IDX) begin
                  idx_d = '0;
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end

`ifdef UART_RX_PARITY_EN
         // Even parity: received bit must equal XOR of the data bits
         PARITY: begin
            if (bit_end) begin
               perr_d  = rx_s ^ (^sh_q);
               state_d = STOP;
            end
         end
`endif

         // Leaving at mid stop bit leaves half a bit to catch the next start
         STOP: begin
            if (bit_end) begin
               if (!rx_s) begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end
`ifdef UART_RX_PARITY_EN
               else if (perr_q) begin
                  pstb_d  = 1'b1;
                  state_d = IDLE;
               end
`endif
               else begin
                  valid_d = 1'b1;
                  data_d  = sh_q;
                  state_d = IDLE;
               end
            end
         end

         // Held-low line: one framing error only, wait for idle high
         BREAK: begin
            cnt_d = '0;
            if (rx_s) state_d = IDLE;
         end

         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any frame in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         sh_q         <= '0;
         data_q       <= '0;
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         sh_q         <= sh_d;
         data_q       <= data_d;
         rx_valid     <= valid_d;
         rx_frame_err <= ferr_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   // Parity mismatch flag and its strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         perr_q        <= 1'b0;
         rx_parity_err <= 1'b0;
      end else begin
         perr_q        <= perr_d;
         rx_parity_err <= pstb_d;
      end
   end
`else
   assign rx_parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver that pairs with `uart_tx`: recovers 8N1 frames (optional even parity) from an asynchronous `rx_serial` line and presents each byte with a one-cycle valid strobe. It sits at the board-facing edge of the serial interface, between the pin and the byte-level consumer such as a command parser or FIFO. It oversamples at `clk`, synchronises the input, rejects start-bit glitches, and flags framing and parity errors.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz
- `BAUD_RATE`, 115200, line rate in bit/s; `CLKS_PER_BIT = CLK_FREQ / BAUD_RATE` (integer division, 434 at defaults)
- `clk`  in  1  system clock; all logic on its rising edge
- `rst`  in  1  reset; one clock, synchronous and active-high
- `rx_serial`  in  1  asynchronous serial input, idle high
- `rx_data`  out  8  last correctly framed byte; held until the next good byte
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates
- `rx_frame_err`  out  1  one-cycle pulse when the stop bit samples 0
- `rx_parity_err`  out  1  one-cycle pulse on parity mismatch; constant 0 when parity is compiled out
- `rx_busy`  out  1  high whenever the FSM is not in IDLE

## Operation
- **Synchroniser:** `rx_serial` passes through two flops before any use; both flops reset to 1.
- **Bit counter:** counts 0..`CLKS_PER_BIT-1`. It clears on every state transition.
- **IDLE:** stay while the synchronised line is 1. A synchronised 0 enters START.
- **START:** at count `CLKS_PER_BIT/2 - 1` (mid start bit), re-sample the line.
  - 0: go to DATA.
  - 1: glitch. Return to IDLE with no strobe.
- **DATA:** each time the count reaches `CLKS_PER_BIT-1`, sample the line into bit `idx` of the shift register, LSB first.
  - `idx` runs 0..7.
  - After bit 7, go to PARITY if parity is compiled in, otherwise to STOP.
- **PARITY:** after one bit period, sample the line and compare it with the XOR of the data bits (even parity). Record any mismatch, then go to STOP.
- **STOP:** after one bit period, sample the line (mid stop bit).
  - 1 and no parity mismatch: load `rx_data`, pulse `rx_valid`, go to IDLE.
  - 1 with parity mismatch: pulse `rx_parity_err`, leave `rx_data` unchanged, go to IDLE.
  - 0: pulse `rx_frame_err`, leave `rx_data` unchanged, go to BREAK.
- **BREAK:** wait for the synchronised line to return to 1, then go to IDLE. A held-low line produces exactly one `rx_frame_err`.
- **No backpressure:** a consumer that misses `rx_valid` loses the byte. Overrun is not detected.

## Timing
- **Reset values:** `rx_data`=0x00, `rx_valid`=0, `rx_frame_err`=0, `rx_parity_err`=0, `rx_busy`=0. FSM=IDLE, counter=0, `idx`=0.
- **Reset mid-frame:** returns to IDLE in the next cycle with no strobe. `rx_data` is cleared.
- **Synchroniser latency:** 2 cycles from a pin edge to the FSM.
- **Strobe latency:**
  - `rx_valid` rises `2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT` cycles (±1) after the start-bit falling edge at the pin.
  - Add `CLKS_PER_BIT` with parity compiled in.
  - The pulse lasts exactly one cycle, and `rx_data` is stable in that same cycle.
- **Back-to-back frames:** IDLE is re-entered at mid stop bit. A start edge arriving immediately after the stop bit (0 idle gap) is received.
- **Strobe exclusivity:** at most one of `rx_valid` / `rx_frame_err` / `rx_parity_err` is high in any cycle.
- **Baud tolerance:** frames from a transmitter within ±2 % of `BAUD_RATE` decode correctly.

## Configuration
- **Macro:** `UART_RX_PARITY_EN`.
- **Defined:** the frame is 8E1. The PARITY state exists and `rx_parity_err` is driven as above.
- **Undefined:** the frame is 8N1. The PARITY state is absent and `rx_parity_err` is tied to 0. All other behaviour is identical.

## Structure
- **Package `uart_pkg`:** holds `uart_rx_state_t` (IDLE, START, DATA, PARITY, STOP, BREAK), the `CLKS_PER_BIT` calculation as a function of `CLK_FREQ` and `BAUD_RATE`, and `UART_DATA_BITS = 8`.
- **`uart_tx`:** imports `uart_pkg` for the shared constants.
- **Sub-module `uart_rx_sync`:** a parameterised two-flop synchroniser with reset value 1. Its only instance is the one in `uart_rx`.

## Test plan
- **Idle after reset:** hold `rst` for 5 cycles, line high for 100 cycles. Required: all outputs at reset values, `rx_busy`=0, no strobes.
- **Single bytes:** drive 0xA5, 0x00 and 0xFF as 8N1 at `BIT_PERIOD` = 8680 ns. Required: one `rx_valid` per byte with `rx_data` equal to the byte, and latency within the stated window.
- **Back-to-back:** send 0x48 then 0x69 with zero idle gap. Required: two `rx_valid` pulses, data 0x48 then 0x69, no error strobes.
- **Glitch and framing error:**
  - Drive the line low for 200 ns (well under half a bit). Required: FSM returns to IDLE and no strobe.
  - Send 0x3C with the stop bit forced to 0 and the line held low for 3 bit periods. Required: exactly one `rx_frame_err`, `rx_data` unchanged, next good byte 0x55 received.
- **Reset mid-frame:** assert `rst` during data bit 4 of 0xC3, then send 0x81. Required: no strobe for 0xC3, `rx_data`=0x00 after reset, then `rx_valid` with 0x81.
- **Parity (`UART_RX_PARITY_EN` defined):**
  - Send 0x07 with parity bit 1. Required: `rx_valid`.
  - Send 0x07 with parity bit 0. Required: `rx_parity_err` and `rx_data` unchanged.
